// File: rtl/stdp_pkg.sv
// Shared types and default constants for the STDP synapse.
// Soft-bound learning is selected with STDP_SOFT_BOUND_EN.
package stdp_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_APPLY
  } state_t;

  localparam int W_INIT_D        = 128;
  localparam int TRACE_MAX_D     = 255;
  localparam int DECAY_SHIFT_D   = 3;
  localparam int A_PLUS_SHIFT_D  = 4;
  localparam int A_MINUS_SHIFT_D = 4;

  function automatic int acc_width(input int w);
    return w + 2;
  endfunction

endpackage

// File: rtl/stdp_trace.sv
// One eligibility trace: reloads on a spike, decays
// geometrically on each prescaler tick.
module stdp_trace
  import stdp_pkg::*;
#(
  parameter int TRACE_WIDTH = 8,
  parameter int TRACE_MAX   = TRACE_MAX_D,
  parameter int DECAY_SHIFT = DECAY_SHIFT_D
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   spike,
  input  logic                   tick,
  output logic [TRACE_WIDTH-1:0] trace
);

  logic [TRACE_WIDTH-1:0] r_trace;
  logic [TRACE_WIDTH-1:0] w_step;

  // Minimum step of one so small traces still reach zero.
  always_comb begin
    w_step = r_trace >> DECAY_SHIFT;
    if (w_step == '0)
      w_step = TRACE_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_trace <= '0;
    else if (spike)
      r_trace <= TRACE_WIDTH'(TRACE_MAX);
    else if (tick && r_trace != '0)
      r_trace <= r_trace - w_step;
  end

  assign trace = r_trace;

endmodule

// File: rtl/stdp_synapse.sv
// Pair-based STDP synapse with saturating weight.
// Define STDP_SOFT_BOUND_EN for multiplicative soft bounds.
module stdp_synapse
  import stdp_pkg::*;
#(
  parameter int W_WIDTH       = 8,
  parameter int TRACE_WIDTH   = 8,
  parameter int TRACE_MAX     = TRACE_MAX_D,
  parameter int DECAY_PERIOD  = 16,
  parameter int DECAY_SHIFT   = DECAY_SHIFT_D,
  parameter int A_PLUS_SHIFT  = A_PLUS_SHIFT_D,
  parameter int A_MINUS_SHIFT = A_MINUS_SHIFT_D,
  parameter int W_INIT        = W_INIT_D,
  parameter int W_MIN         = 0,
  parameter int W_MAX         = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pre_spike,
  input  logic                   post_spike,
  input  logic                   learn_en,
  output logic [W_WIDTH-1:0]     weight,
  output logic                   weight_valid,
  output logic                   sat_event,
  output logic                   busy,
  output logic [TRACE_WIDTH-1:0] pre_trace,
  output logic [TRACE_WIDTH-1:0] post_trace
);

  localparam int AW = acc_width(W_WIDTH);
  localparam int PW = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
  localparam logic signed [AW:0] ACC_LIM = (AW+1)'((1 << W_WIDTH) - 1);
  localparam logic signed [AW:0] WMAX_S  = (AW+1)'(W_MAX);
  localparam logic signed [AW:0] WMIN_S  = (AW+1)'(W_MIN);

  logic [PW-1:0]          r_presc;
  logic                   w_tick;
  logic [TRACE_WIDTH-1:0] w_pre;
  logic [TRACE_WIDTH-1:0] w_post;
  logic [TRACE_WIDTH-1:0] w_ltp_base;
  logic [TRACE_WIDTH-1:0] w_ltd_base;
  logic signed [AW-1:0]   w_ltp;
  logic signed [AW-1:0]   w_ltd;
  logic signed [AW-1:0]   w_net;
  logic signed [AW-1:0]   w_base;
  logic signed [AW:0]     w_sum;
  logic signed [AW-1:0]   w_acc_nxt;
  logic signed [AW-1:0]   r_acc;
  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   w_write;
  logic signed [AW:0]     w_wsum;
  logic [W_WIDTH-1:0]     w_wnew;
  logic                   w_clamp;
  logic [W_WIDTH-1:0]     r_weight;
  logic                   r_valid;
  logic                   r_sat;

  assign w_tick = (r_presc == PW'(DECAY_PERIOD - 1));

  always_ff @(posedge clk) begin
    if (rst || w_tick)
      r_presc <= '0;
    else
      r_presc <= r_presc + PW'(1);
  end

  stdp_trace #(
    .TRACE_WIDTH(TRACE_WIDTH),
    .TRACE_MAX  (TRACE_MAX),
    .DECAY_SHIFT(DECAY_SHIFT)
  ) u_pre (
    .clk  (clk),
    .rst  (rst),
    .spike(pre_spike),
    .tick (w_tick),
    .trace(w_pre)
  );

  stdp_trace #(
    .TRACE_WIDTH(TRACE_WIDTH),
    .TRACE_MAX  (TRACE_MAX),
    .DECAY_SHIFT(DECAY_SHIFT)
  ) u_post (
    .clk  (clk),
    .rst  (rst),
    .spike(post_spike),
    .tick (w_tick),
    .trace(w_post)
  );

  assign w_ltp_base = w_pre >> A_PLUS_SHIFT;
  assign w_ltd_base = w_post >> A_MINUS_SHIFT;

`ifdef STDP_SOFT_BOUND_EN
  localparam int PD = TRACE_WIDTH + W_WIDTH;
  logic [PD-1:0] w_ltp_prod;
  logic [PD-1:0] w_ltd_prod;
  assign w_ltp_prod = PD'(w_ltp_base) * PD'(W_WIDTH'(W_MAX) - r_weight);
  assign w_ltd_prod = PD'(w_ltd_base) * PD'(r_weight - W_WIDTH'(W_MIN));
  assign w_ltp = AW'(w_ltp_prod >> W_WIDTH);
  assign w_ltd = AW'(w_ltd_prod >> W_WIDTH);
`else
  assign w_ltp = AW'(w_ltp_base);
  assign w_ltd = AW'(w_ltd_base);
`endif

  always_comb begin
    w_net = '0;
    if (learn_en) begin
      if (post_spike)
        w_net = w_net + w_ltp;
      if (pre_spike)
        w_net = w_net - w_ltd;
    end
  end

  // In APPLY the old acc is consumed by the weight write.
  always_comb begin
    w_base = (r_state == ST_APPLY) ? '0 : r_acc;
    w_sum  = {w_base[AW-1], w_base} + {w_net[AW-1], w_net};
    if (w_sum > ACC_LIM)
      w_acc_nxt = AW'(ACC_LIM);
    else if (w_sum < -ACC_LIM)
      w_acc_nxt = AW'(-ACC_LIM);
    else
      w_acc_nxt = AW'(w_sum);
  end

  always_ff @(posedge clk) begin
    if (rst || !learn_en)
      r_acc <= '0;
    else
      r_acc <= w_acc_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_write     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (learn_en && r_acc != '0)
          w_state_nxt = ST_APPLY;
      end
      ST_APPLY: begin
        w_state_nxt = ST_IDLE;
        w_write     = 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_wsum  = $signed({1'b0, AW'(r_weight)}) + {r_acc[AW-1], r_acc};
    w_clamp = 1'b1;
    if (w_wsum > WMAX_S)
      w_wnew = W_WIDTH'(W_MAX);
    else if (w_wsum < WMIN_S)
      w_wnew = W_WIDTH'(W_MIN);
    else begin
      w_wnew  = W_WIDTH'(w_wsum);
      w_clamp = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_weight <= W_WIDTH'(W_INIT);
      r_valid  <= 1'b0;
      r_sat    <= 1'b0;
    end else begin
      r_valid <= w_write;
      r_sat   <= w_write & w_clamp;
      if (w_write)
        r_weight <= w_wnew;
    end
  end

  assign weight       = r_weight;
  assign weight_valid = r_valid;
  assign sat_event    = r_sat;
  assign busy         = (r_state == ST_APPLY);
  assign pre_trace    = w_pre;
  assign post_trace   = w_post;

endmodule

// File: tb/tb_stdp_synapse.sv
// Scoreboard bench for stdp_synapse (additive build).
`timescale 1ns/1ps
module tb_stdp_synapse;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pre_spike = 1'b0;
  logic       post_spike = 1'b0;
  logic       learn_en = 1'b1;
  logic [7:0] weight;
  logic       weight_valid;
  logic       sat_event;
  logic       busy;
  logic [7:0] pre_trace;
  logic [7:0] post_trace;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [7:0] w;
    logic       s;
  } exp_t;

  exp_t q[$];

  stdp_synapse dut (
    .clk         (clk),
    .rst         (rst),
    .pre_spike   (pre_spike),
    .post_spike  (post_spike),
    .learn_en    (learn_en),
    .weight      (weight),
    .weight_valid(weight_valid),
    .sat_event   (sat_event),
    .busy        (busy),
    .pre_trace   (pre_trace),
    .post_trace  (post_trace)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  task automatic push(input int w, input int s);
    exp_t e;
    e.w = 8'(w);
    e.s = 1'(s);
    q.push_back(e);
  endtask

  // Load pre_trace without any LTD, then LTP via a post spike.
  task automatic ltp_pair(input int w, input int s);
    learn_en = 1'b0;
    pre_spike = 1'b1;
    step();
    pre_spike = 1'b0;
    learn_en = 1'b1;
    push(w, s);
    post_spike = 1'b1;
    step();
    post_spike = 1'b0;
    step(4);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (weight_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got weight %0d expected no write",
                   weight);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("write_weight", int'(weight), int'(e.w));
          chk("write_sat", int'(sat_event), int'(e.s));
        end
      end else if (sat_event) begin
        chk("sat_without_valid", int'(sat_event), 0);
      end
    end
  end

  initial begin
    do_reset();
    chk("rst_weight", int'(weight), 128);
    chk("rst_pre", int'(pre_trace), 0);
    chk("rst_post", int'(post_trace), 0);
    chk("rst_valid", int'(weight_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_sat", int'(sat_event), 0);

    // basic LTP
    push(143, 0);
    pre_spike = 1'b1;
    step();
    pre_spike = 1'b0;
    post_spike = 1'b1;
    step();
    post_spike = 1'b0;
    chk("ltp_pre_trace", int'(pre_trace), 255);
    step();
    chk("ltp_busy", int'(busy), 1);
    step(4);

    // simultaneous spikes, then LTD
    do_reset();
    pre_spike = 1'b1;
    post_spike = 1'b1;
    step();
    pre_spike = 1'b0;
    post_spike = 1'b0;
    chk("sim_pre", int'(pre_trace), 255);
    chk("sim_post", int'(post_trace), 255);
    push(113, 0);
    pre_spike = 1'b1;
    step();
    pre_spike = 1'b0;
    chk("sim_busy", int'(busy), 0);
    step(5);

    // decay by one tick, then LTP from 224
    do_reset();
    step(16);
    pre_spike = 1'b1;
    step();
    pre_spike = 1'b0;
    step(14);
    chk("decay_before_tick", int'(pre_trace), 255);
    step();
    chk("decay_one_tick", int'(pre_trace), 224);
    push(142, 0);
    post_spike = 1'b1;
    step();
    post_spike = 1'b0;
    step(1000);
    chk("decay_pre_zero", int'(pre_trace), 0);
    chk("decay_post_zero", int'(post_trace), 0);
    step(40);
    chk("decay_pre_hold", int'(pre_trace), 0);
    chk("decay_post_hold", int'(post_trace), 0);

    // climb to 248, +2 from a decayed trace, then clamp
    do_reset();
    for (int i = 1; i <= 8; i++)
      ltp_pair(128 + 15 * i, 0);
    learn_en = 1'b0;
    pre_spike = 1'b1;
    step();
    pre_spike = 1'b0;
    learn_en = 1'b1;
    step(240);
    push(250, 0);
    post_spike = 1'b1;
    step();
    post_spike = 1'b0;
    step(4);
    ltp_pair(255, 1);

    // learning disabled: traces move, weight does not
    learn_en = 1'b0;
    pre_spike = 1'b1;
    step();
    pre_spike = 1'b0;
    chk("gate_pre", int'(pre_trace), 255);
    post_spike = 1'b1;
    step();
    post_spike = 1'b0;
    chk("gate_post", int'(post_trace), 255);
    step(4);
    chk("gate_weight", int'(weight), 255);
    chk("gate_busy", int'(busy), 0);

    // reset while in APPLY discards the write
    learn_en = 1'b0;
    pre_spike = 1'b1;
    step();
    pre_spike = 1'b0;
    learn_en = 1'b1;
    post_spike = 1'b1;
    step();
    post_spike = 1'b0;
    step();
    chk("rstapply_busy", int'(busy), 1);
    do_reset();
    chk("rstapply_weight", int'(weight), 128);
    chk("rstapply_busy_after", int'(busy), 0);
    chk("rstapply_pre", int'(pre_trace), 0);
    step(3);

    // learn_en dropped in APPLY still completes the write
    learn_en = 1'b0;
    pre_spike = 1'b1;
    step();
    pre_spike = 1'b0;
    learn_en = 1'b1;
    push(143, 0);
    post_spike = 1'b1;
    step();
    post_spike = 1'b0;
    step();
    chk("drop_busy", int'(busy), 1);
    learn_en = 1'b0;
    step(4);
    learn_en = 1'b1;

    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
